mem_stage: RTL

- MEM stage of the 5-stage MIPS pipeline; the consumer of the EX/MEM register outputs produced by the execute stage.
- Owns the byte-addressed, little-endian data memory. Performs width- and sign-aware loads and stores, and holds the MEM/WB pipeline register that feeds write-back and the MEM/WB forwarding path.
- Advances only when i_step is high, so the debug unit can single-step the pipeline.
- Provides a combinational debug read port for memory dumps.

---
 rtl/mem_stage.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// MEM stage: byte-addressed little-endian data memory plus the MEM/WB pipeline register.
// Latency: 1 stepped clk edge from the EX/MEM inputs to the MEM/WB outputs; o_dbg_data is combinational.
// Backpressure: none; i_step=0 freezes the stage, so no store and no register update happen.
//
// Ports:
//   clk, i_reset          rising-edge clock; asynchronous active-low reset
//   i_step                pipeline advance enable
//   i_mem2reg, i_memWrite, i_regWrite, i_width, i_sign_flag, i_write_reg,
//   i_result, i_data4Mem  EX/MEM register contents (i_result is the byte address)
//   o_mem2reg, o_regWrite, o_write_reg, o_read_data, o_result  MEM/WB register
//   o_misaligned          sticky misaligned-access flag, cleared only by reset
//   i_dbg_addr, o_dbg_data  combinational debug read of one memory word
module mem_stage #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 8
) (
  input  logic               clk,
  input  logic               i_reset,
  input  logic               i_step,
  input  logic               i_mem2reg,
  input  logic               i_memWrite,
  input  logic               i_regWrite,
  input  logic [1:0]         i_width,
  input  logic               i_sign_flag,
  input  logic [4:0]         i_write_reg,
  input  logic [NB_DATA-1:0] i_result,
  input  logic [NB_DATA-1:0] i_data4Mem,
  input  logic [NB_ADDR-1:0] i_dbg_addr,
  output logic               o_mem2reg,
  output logic               o_regWrite,
  output logic [4:0]         o_write_reg,
  output logic [NB_DATA-1:0] o_read_data,
  output logic [NB_DATA-1:0] o_result,
  output logic               o_misaligned,
  output logic [NB_DATA-1:0] o_dbg_data
);

  localparam int NB_LANES = NB_DATA / 8;
  localparam int NB_BA    = NB_ADDR + 2;

  // Storage is deliberately not reset: contents survive a pipeline reset.
  logic [NB_DATA-1:0] mem_q [2**NB_ADDR];

  // ---------------------------------------------------------------- decode
  logic [NB_BA-1:0]   ba;
  logic [NB_ADDR-1:0] widx;
  logic [1:0]         lane;
  logic               is_half;
  logic               is_word;
  logic               misaligned;

  // Address bits above the memory size are dropped, so accesses wrap.
  assign ba      = i_result[NB_BA-1:0];
  assign widx    = ba[NB_BA-1:2];
  assign lane    = ba[1:0];
  assign is_half = (i_width == 2'b01);
  assign is_word = i_width[1];
  assign misaligned = (is_half & ba[0]) | (is_word & (lane != 2'b00));

  logic unused_upper_addr;
  assign unused_upper_addr = ^i_result[NB_DATA-1:NB_BA];

  // ------------------------------------------------------------- load path
  logic [NB_DATA-1:0] rd_word;
  logic [7:0]         ld_byte;
  logic [15:0]        ld_half;
  logic [NB_DATA-1:0] ld_ext;

  assign rd_word = mem_q[widx];
  assign ld_byte = rd_word[{lane, 3'b000} +: 8];
  assign ld_half = rd_word[{ba[1], 4'b0000} +: 16];

  always_comb begin
    ld_ext = '0;
    if (!misaligned) begin
      if (is_word) begin
        ld_ext = rd_word;
      end else if (is_half) begin
        ld_ext = i_sign_flag ? {{(NB_DATA-16){ld_half[15]}}, ld_half}
                             : {{(NB_DATA-16){1'b0}}, ld_half};
      end else begin
        ld_ext = i_sign_flag ? {{(NB_DATA-8){ld_byte[7]}}, ld_byte}
                             : {{(NB_DATA-8){1'b0}}, ld_byte};
      end
    end
  end

  // ------------------------------------------------------------ store path
  logic                store_en;
  logic [NB_LANES-1:0] be;
  logic [NB_DATA-1:0]  wdata;

  // Reset gates the store too, so a reset landing mid-step cancels it.
  assign store_en = i_reset & i_step & i_memWrite & ~misaligned;

  // Store data is replicated across lanes; the byte enables pick the target.
  always_comb begin
    be    = '0;
    wdata = i_data4Mem;
    if (is_word) begin
      be = '1;
    end else if (is_half) begin
      be[{ba[1], 1'b0} +: 2] = 2'b11;
      wdata = {(NB_DATA/16){i_data4Mem[15:0]}};
    end else begin
      be[lane] = 1'b1;
      wdata = {NB_LANES{i_data4Mem[7:0]}};
    end
  end

  always_ff @(posedge clk) begin
    if (store_en) begin
      for (int b = 0; b < NB_LANES; b++) begin
        if (be[b]) mem_q[widx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign o_dbg_data = mem_q[i_dbg_addr];

  // -------------------------------------------------------- MEM/WB register
  logic               mem2reg_q,  mem2reg_d;
  logic               regwrite_q, regwrite_d;
  logic [4:0]         write_reg_q, write_reg_d;
  logic [NB_DATA-1:0] read_data_q, read_data_d;
  logic [NB_DATA-1:0] result_q,   result_d;
  logic               mis_q,      mis_d;

  always_comb begin
    mem2reg_d   = mem2reg_q;
    regwrite_d  = regwrite_q;
    write_reg_d = write_reg_q;
    read_data_d = read_data_q;
    result_d    = result_q;
    mis_d       = mis_q;
    if (i_step) begin
      mem2reg_d   = i_mem2reg;
      regwrite_d  = i_regWrite;
      write_reg_d = i_write_reg;
      read_data_d = ld_ext;
      result_d    = i_result;
      // Only real memory accesses can flag misalignment.
      if ((i_memWrite | i_mem2reg) & misaligned) mis_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      mem2reg_q   <= 1'b0;
      regwrite_q  <= 1'b0;
      write_reg_q <= '0;
      read_data_q <= '0;
      result_q    <= '0;
      mis_q       <= 1'b0;
    end else begin
      mem2reg_q   <= mem2reg_d;
      regwrite_q  <= regwrite_d;
      write_reg_q <= write_reg_d;
      read_data_q <= read_data_d;
      result_q    <= result_d;
      mis_q       <= mis_d;
    end
  end

  assign o_mem2reg    = mem2reg_q;
  assign o_regWrite   = regwrite_q;
  assign o_write_reg  = write_reg_q;
  assign o_read_data  = read_data_q;
  assign o_result     = result_q;
  assign o_misaligned = mis_q;

endmodule
